branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Direct-mapped BTB with 2-bit saturating counters; upstream of the fetch stage.
//  Looks up the current fetch PC and drives hit/predicted target into the fetch PC mux.
//  Resolves branches from EX: updates the table and emits the 2-bit redirect select
//  plus recovery PC consumed by the fetch 3:1 PC mux.
// PARAMETERS
//  ENTRIES  64              number of BTB entries, power of 2, >=4
//  IDX_W    $clog2(ENTRIES) index width; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]
// PORTS
//  clk_i                 in   1   clock
//  rst_ni                in   1   reset, asynchronous, active-low
//  pc_i                  in   32  current fetch PC (lookup address)
//  hit_o                 out  1   predict taken: entry valid & tag match & cnt[1]
//  predicted_pc_o        out  32  stored target of matching entry, else 0
//  ex_valid_i            in   1   EX holds a real (non-bubble) instruction
//  ex_is_branch_i        in   1   EX instruction is branch/jump
//  ex_taken_i            in   1   resolved direction
//  ex_pc_i               in   32  PC of EX instruction
//  ex_pc4_i              in   32  PC+4 of EX instruction
//  ex_target_i           in   32  resolved target (ALU PC)
//  ex_hit_i              in   1   hit_o value piped down with this instruction
//  ex_pred_target_i      in   32  predicted_pc_o piped down with this instruction
//  wrong_predicted_o     out  2   00 none, 01 redirect to mispredicted_pc_o, 10 redirect to ALU PC
//  mispredicted_pc_o     out  32  recovery PC for select 01 (= ex_pc4_i)
//  no_branch_o           out  32  resolved-branch count (stats)
//  no_mispred_o          out  32  mispredict count (stats)
// BEHAVIOUR
//  Reset: all valid bits 0, counters 2'b01, tags/targets 0, stats 0; hit_o=0, predicted_pc_o=0,
//   wrong_predicted_o=00 whenever ex_valid_i=0.
//  Lookup: purely combinational from pc_i and table state (0-cycle latency); pc_i[1:0] ignored.
//  Redirect (combinational, only when ex_valid_i=1), priority top-down:
//   ex_is_branch_i=0 & ex_hit_i=1               -> 01 (alias/stale entry)
//   ex_is_branch_i=1 & ex_hit_i=1 & !ex_taken_i -> 01
//   ex_taken_i=1 & (!ex_hit_i | ex_pred_target_i!=ex_target_i) -> 10
//   otherwise -> 00.  mispredicted_pc_o = ex_pc4_i always.
//  Update at posedge, when ex_valid_i=1, index/tag from ex_pc_i:
//   branch, tag match: counter sat-inc if taken else sat-dec (11 and 00 saturate);
//    target <= ex_target_i if taken.
//   branch, no match, taken: allocate/replace: valid=1, tag, target, counter=2'b10.
//   branch, no match, not taken: no write.
//   non-branch, tag match & valid: invalidate entry (valid=0).
//  Same-index lookup and update in one cycle: lookup returns pre-update contents.
//  Reset asserted mid-operation: table and stats cleared immediately; any pending update lost.
// CONFIGURATION
//  BP_STATS_EN defined: no_branch_o += 1 per valid branch resolved; no_mispred_o += 1 per
//   cycle wrong_predicted_o!=00; both wrap at 2^32.
//  BP_STATS_EN undefined: counters not built; no_branch_o, no_mispred_o tied to 0.
// STRUCTURE
//  Package bp_def: bp_cnt_t (logic[1:0]), btb_entry_t struct {valid, tag, target, cnt},
//   constants BP_NONE=2'b00, BP_PC4=2'b01, BP_ALU=2'b10, BP_CNT_RST=2'b01, BP_CNT_ALLOC=2'b10.
//  Sub-module bp_sat_cnt: 2-bit saturating up/down next-value function (combinational).
//  Table: flop array of btb_entry_t, async-reset; no SRAM.
// TESTING
//  1 Reset, pc_i=0x40 -> hit_o=0, predicted_pc_o=0, wrong_predicted_o=00.
//  2 EX branch pc=0x40 taken target=0x100, ex_hit_i=0 -> wrong_predicted_o=10; next cycle
//    pc_i=0x40 -> hit_o=1, predicted_pc_o=0x100.
//  3 Same branch resolved not-taken, ex_hit_i=1 -> 01, mispredicted_pc_o=0x44; counter 10->01,
//    then pc_i=0x40 -> hit_o=0.
//  4 Taken 3x from 10 -> counter 11, stays 11; one not-taken -> 10, hit_o still 1.
//  5 Aliasing: ENTRIES=64, pc 0x40 entry valid, EX non-branch at 0x40 with ex_hit_i=1 -> 01,
//    entry invalidated; lookup 0x140 (same index, other tag) -> hit_o=0.
//  6 BP_STATS_EN: 5 branches, 2 mispredicts -> no_branch_o=5, no_mispred_o=2; async reset
//    mid-run -> both 0 and all hits cleared same cycle.

Source files
------------

// File: rtl/bp_def.sv
// Shared types and constants for the branch target predictor.
// The BTB entry holds its tag in a fixed 30-bit field. Tags narrower than 30 bits
// are zero-extended, so one struct serves every ENTRIES setting.
package bp_def;

    typedef logic [1:0] bp_cnt_t;

    // Widest tag possible: pc[31:2] with a zero-width index
    localparam int BP_TAG_MAX_W = 30;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_MAX_W-1:0] tag;
        logic [31:0]             target;
        bp_cnt_t                 cnt;
    } btb_entry_t;

    // Redirect select encodings for the fetch 3:1 PC mux
    localparam logic [1:0] BP_NONE = 2'b00;
    localparam logic [1:0] BP_PC4  = 2'b01;
    localparam logic [1:0] BP_ALU  = 2'b10;

    // Counter values: weakly not-taken after reset, weakly taken on allocation
    localparam bp_cnt_t BP_CNT_RST   = 2'b01;
    localparam bp_cnt_t BP_CNT_ALLOC = 2'b10;

    // Contents of an entry after reset
    function automatic btb_entry_t bp_entry_rst();
        btb_entry_t e;
        e.valid  = 1'b0;
        e.tag    = '0;
        e.target = '0;
        e.cnt    = BP_CNT_RST;
        return e;
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// 2-bit saturating up/down counter next-value function (purely combinational).
// 11 saturates on increment; 00 saturates on decrement.
module bp_sat_cnt
    import bp_def::*;
(
    input  bp_cnt_t cnt,
    input  logic    up,
    output bp_cnt_t cnt_next
);

    // Step towards the requested direction unless already at the rail
    always_comb begin
        cnt_next = cnt;
        if (up) begin
            if (cnt != 2'b11) begin
                cnt_next = cnt + 2'b01;
            end
        end else begin
            if (cnt != 2'b00) begin
                cnt_next = cnt - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup of the fetch PC is combinational.
// Resolution from EX produces a redirect select and the recovery PC in the same cycle,
// and the table is written at the next clock edge.
// Optional statistics counters are built only when BP_STATS_EN is defined.
// Otherwise no_branch_o and no_mispred_o are tied to zero.
module branch_target_predictor
    import bp_def::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    output logic        hit_o,
    output logic [31:0] predicted_pc_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_pc4_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_hit_i,
    input  logic [31:0] ex_pred_target_i,
    output logic [1:0]  wrong_predicted_o,
    output logic [31:0] mispredicted_pc_o,
    output logic [31:0] no_branch_o,
    output logic [31:0] no_mispred_o
);

    localparam int TAG_W = 30 - IDX_W;

    btb_entry_t table_reg [ENTRIES];

    // Fetch-side lookup signals
    logic [IDX_W-1:0]        lk_idx;
    logic [BP_TAG_MAX_W-1:0] lk_tag;
    btb_entry_t              lk_entry;
    logic                    lk_match;

    // EX-side update signals
    logic [IDX_W-1:0]        ex_idx;
    logic [BP_TAG_MAX_W-1:0] ex_tag;
    btb_entry_t              ex_entry;
    logic                    ex_match;
    bp_cnt_t                 ex_cnt_next;
    logic                    upd_en;
    btb_entry_t              upd_entry;

    // The low two PC bits never select anything (word-aligned fetch)
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[1:0], ex_pc_i[1:0]};

    assign lk_idx   = pc_i[IDX_W+1:2];
    assign lk_tag   = {{IDX_W{1'b0}}, pc_i[31:IDX_W+2]};
    assign lk_entry = table_reg[lk_idx];
    assign lk_match = lk_entry.valid && (lk_entry.tag == lk_tag);

    // Lookup: predict taken only on a matching entry whose counter leans taken
    always_comb begin
        hit_o          = lk_match && lk_entry.cnt[1];
        predicted_pc_o = lk_match ? lk_entry.target : 32'h0;
    end

    assign ex_idx   = ex_pc_i[IDX_W+1:2];
    assign ex_tag   = {{IDX_W{1'b0}}, ex_pc_i[31:IDX_W+2]};
    assign ex_entry = table_reg[ex_idx];
    assign ex_match = ex_entry.valid && (ex_entry.tag == ex_tag);

    bp_sat_cnt u_sat_cnt (
        .cnt      (ex_entry.cnt),
        .up       (ex_taken_i),
        .cnt_next (ex_cnt_next)
    );

    // Redirect select. A non-branch that hit means the prediction came from an
    // aliased or stale entry, so fetch resumes at PC+4.
    always_comb begin
        wrong_predicted_o = BP_NONE;
        if (ex_valid_i) begin
            if (!ex_is_branch_i && ex_hit_i) begin
                wrong_predicted_o = BP_PC4;
            end else if (ex_is_branch_i && ex_hit_i && !ex_taken_i) begin
                wrong_predicted_o = BP_PC4;
            end else if (ex_taken_i && (!ex_hit_i || (ex_pred_target_i != ex_target_i))) begin
                wrong_predicted_o = BP_ALU;
            end
        end
    end

    assign mispredicted_pc_o = ex_pc4_i;

    // Choose the table write for the resolving instruction: train, allocate or invalidate
    always_comb begin
        upd_en    = 1'b0;
        upd_entry = ex_entry;
        if (ex_valid_i) begin
            if (ex_is_branch_i) begin
                if (ex_match) begin
                    upd_en        = 1'b1;
                    upd_entry.cnt = ex_cnt_next;
                    if (ex_taken_i) begin
                        upd_entry.target = ex_target_i;
                    end
                end else if (ex_taken_i) begin
                    upd_en           = 1'b1;
                    upd_entry.valid  = 1'b1;
                    upd_entry.tag    = ex_tag;
                    upd_entry.target = ex_target_i;
                    upd_entry.cnt    = BP_CNT_ALLOC;
                end
            end else if (ex_match) begin
                upd_en          = 1'b1;
                upd_entry.valid = 1'b0;
            end
        end
    end

    // Table storage. Reset clears every entry, and a write lands at the clock edge,
    // so a same-cycle lookup still sees the old contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_reg[i] <= bp_entry_rst();
            end
        end else if (upd_en) begin
            table_reg[ex_idx] <= upd_entry;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] no_branch_reg;
    logic [31:0] no_mispred_reg;

    // Statistics: resolved branches and redirect cycles, wrapping at 2^32
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            no_branch_reg  <= 32'h0;
            no_mispred_reg <= 32'h0;
        end else begin
            if (ex_valid_i && ex_is_branch_i) begin
                no_branch_reg <= no_branch_reg + 32'h1;
            end
            if (wrong_predicted_o != BP_NONE) begin
                no_mispred_reg <= no_mispred_reg + 32'h1;
            end
        end
    end

    assign no_branch_o  = no_branch_reg;
    assign no_mispred_o = no_mispred_reg;
`else
    assign no_branch_o  = 32'h0;
    assign no_mispred_o = 32'h0;
`endif

    // The tag width check keeps the struct field wide enough for any legal ENTRIES value
    logic unused_tag_w;
    assign unused_tag_w = (TAG_W > 0);

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed testbench for branch_target_predictor (ENTRIES=64).
// Expected values are queued when stimulus is driven and popped at each check.
// The statistics expectations follow BP_STATS_EN.
module tb_branch_target_predictor;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_i;
    logic        hit_o;
    logic [31:0] predicted_pc_o;
    logic        ex_valid_i;
    logic        ex_is_branch_i;
    logic        ex_taken_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_pc4_i;
    logic [31:0] ex_target_i;
    logic        ex_hit_i;
    logic [31:0] ex_pred_target_i;
    logic [1:0]  wrong_predicted_o;
    logic [31:0] mispredicted_pc_o;
    logic [31:0] no_branch_o;
    logic [31:0] no_mispred_o;

    always #5 clk_i = ~clk_i;

    branch_target_predictor #(.ENTRIES(64)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .pc_i              (pc_i),
        .hit_o             (hit_o),
        .predicted_pc_o    (predicted_pc_o),
        .ex_valid_i        (ex_valid_i),
        .ex_is_branch_i    (ex_is_branch_i),
        .ex_taken_i        (ex_taken_i),
        .ex_pc_i           (ex_pc_i),
        .ex_pc4_i          (ex_pc4_i),
        .ex_target_i       (ex_target_i),
        .ex_hit_i          (ex_hit_i),
        .ex_pred_target_i  (ex_pred_target_i),
        .wrong_predicted_o (wrong_predicted_o),
        .mispredicted_pc_o (mispredicted_pc_o),
        .no_branch_o       (no_branch_o),
        .no_mispred_o      (no_mispred_o)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_branches = 0;
    int   exp_mispred  = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val && tag == e.tag) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h (queued %s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    // One EX resolution. Entered at a falling edge; checks the redirect,
    // lets the rising edge commit the update, and returns at the next falling edge.
    task automatic ex_step(input logic valid, input logic br, input logic taken,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic hit, input logic [31:0] pred,
                           input logic [1:0] exp_wp);
        ex_valid_i       = valid;
        ex_is_branch_i   = br;
        ex_taken_i       = taken;
        ex_pc_i          = pc;
        ex_pc4_i         = pc + 32'h4;
        ex_target_i      = tgt;
        ex_hit_i         = hit;
        ex_pred_target_i = pred;
        push_exp("wrong_predicted", {30'h0, exp_wp});
        push_exp("mispredicted_pc", pc + 32'h4);
        #1;
        check("wrong_predicted", {30'h0, wrong_predicted_o});
        check("mispredicted_pc", mispredicted_pc_o);
        $display("[TB] ex valid=%0b br=%0b taken=%0b pc=%h tgt=%h hit=%0b -> wp=%b", valid, br, taken, pc, tgt, hit, wrong_predicted_o);
        if (valid && br) exp_branches++;
        if (exp_wp != 2'b00) exp_mispred++;
        @(posedge clk_i);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
    endtask

    // Fetch-side lookup with EX idle
    task automatic lookup(input logic [31:0] pc, input logic exp_hit, input logic [31:0] exp_pred);
        ex_valid_i = 1'b0;
        pc_i = pc;
        push_exp("hit", {31'h0, exp_hit});
        push_exp("predicted_pc", exp_pred);
        #1;
        check("hit", {31'h0, hit_o});
        check("predicted_pc", predicted_pc_o);
        $display("[TB] lookup pc=%h -> hit=%0b pred=%h", pc, hit_o, predicted_pc_o);
        @(negedge clk_i);
    endtask

    task automatic check_stats();
`ifdef BP_STATS_EN
        push_exp("no_branch", 32'(exp_branches));
        push_exp("no_mispred", 32'(exp_mispred));
`else
        push_exp("no_branch", 32'h0);
        push_exp("no_mispred", 32'h0);
`endif
        check("no_branch", no_branch_o);
        check("no_mispred", no_mispred_o);
        $display("[TB] stats branches=%0d mispred=%0d", no_branch_o, no_mispred_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        pc_i = 32'h40;
        ex_valid_i = 1'b0;
        ex_is_branch_i = 1'b0;
        ex_taken_i = 1'b0;
        ex_pc_i = 32'h0;
        ex_pc4_i = 32'h0;
        ex_target_i = 32'h0;
        ex_hit_i = 1'b0;
        ex_pred_target_i = 32'h0;

        // Reset state
        @(negedge clk_i);
        lookup(32'h40, 1'b0, 32'h0);
        push_exp("wrong_predicted", 32'h0);
        check("wrong_predicted", {30'h0, wrong_predicted_o});
        check_stats();
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Allocate on a taken miss. The same-cycle lookup still sees the empty entry.
        pc_i = 32'h40;
        push_exp("hit", 32'h0);
        #1;
        check("hit", {31'h0, hit_o});
        ex_step(1, 1, 1, 32'h40, 32'h100, 0, 32'h0, 2'b10);
        lookup(32'h40, 1'b1, 32'h100);

        // Not taken after a hit: redirect to PC+4, counter 10 -> 01
        ex_step(1, 1, 0, 32'h40, 32'h100, 1, 32'h100, 2'b01);
        lookup(32'h40, 1'b0, 32'h100);

        // Decrement saturates at 00; it then takes two taken results to predict again
        ex_step(1, 1, 0, 32'h40, 32'h100, 0, 32'h100, 2'b00);
        ex_step(1, 1, 0, 32'h40, 32'h100, 0, 32'h100, 2'b00);
        ex_step(1, 1, 1, 32'h40, 32'h100, 0, 32'h100, 2'b10);
        lookup(32'h40, 1'b0, 32'h100);
        ex_step(1, 1, 1, 32'h40, 32'h100, 0, 32'h100, 2'b10);
        lookup(32'h40, 1'b1, 32'h100);

        // Taken three times saturates at 11; one not-taken leaves it predicting taken
        for (int i = 0; i < 3; i++) begin
            ex_step(1, 1, 1, 32'h40, 32'h100, 1, 32'h100, 2'b00);
        end
        ex_step(1, 1, 0, 32'h40, 32'h100, 1, 32'h100, 2'b01);
        lookup(32'h40, 1'b1, 32'h100);

        // Hit with a wrong target: redirect to the ALU PC and retrain the target
        ex_step(1, 1, 1, 32'h40, 32'h200, 1, 32'h100, 2'b10);
        lookup(32'h40, 1'b1, 32'h200);

        // A non-branch that hit invalidates the entry
        ex_step(1, 0, 0, 32'h40, 32'h0, 1, 32'h200, 2'b01);
        lookup(32'h40, 1'b0, 32'h0);
        lookup(32'h140, 1'b0, 32'h0);

        // A non-branch without a hit changes nothing
        ex_step(1, 0, 0, 32'h80, 32'h0, 0, 32'h0, 2'b00);

        // A bubble never redirects or writes the table
        ex_step(0, 1, 1, 32'h80, 32'h300, 0, 32'h0, 2'b00);
        lookup(32'h80, 1'b0, 32'h0);

        // A not-taken miss does not allocate
        ex_step(1, 1, 0, 32'hC0, 32'h400, 0, 32'h0, 2'b00);
        lookup(32'hC0, 1'b0, 32'h0);

        // Same index, different tag: the second allocation replaces the first
        ex_step(1, 1, 1, 32'h40, 32'h500, 0, 32'h0, 2'b10);
        ex_step(1, 1, 1, 32'h140, 32'h600, 0, 32'h0, 2'b10);
        lookup(32'h40, 1'b0, 32'h0);
        lookup(32'h140, 1'b1, 32'h600);
        check_stats();

        // Reset asserted mid-cycle clears the table and statistics immediately
        pc_i = 32'h140;
        #2;
        rst_ni = 1'b0;
        exp_branches = 0;
        exp_mispred = 0;
        #1;
        push_exp("hit", 32'h0);
        check("hit", {31'h0, hit_o});
        check_stats();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        lookup(32'h140, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
